enemy_controller_param: RTL and testbench
=========================================

Name: enemy_controller_param

Overview:
- Parametrised successor to the single-type enemy controllers.
- Spawns one enemy sprite, moves it horizontally in a ping-pong pattern with optional descent on each bounce, and tracks HP against N_BULLETS player bullets.
- Adds post-hit invulnerability with a flash flag, a timed death phase, a kill pulse, and per-bullet hit pulses so the bullet pool can retire consumed bullets.
- Sits between the bullet pool and the sprite renderer/score logic, in the clk25 domain.

Parameters:
N_BULLETS, 8, number of bullet slots checked
SIZE, 32, enemy sprite edge in pixels
BULLET_SIZE, 8, bullet box edge in pixels
MAX_HP, 10, HP loaded at spawn (1..15)
SPAWN_X, 320, spawn x
SPAWN_Y, 50, spawn y
X_MIN, 10, left turn bound
X_MAX, 598, right turn bound (640-SIZE-10)
Y_MAX, 400, descent limit
MOVE_PERIOD, 500000, clk25 cycles per move step
MOVE_STEP, 2, pixels per horizontal step
DESCEND_STEP, 0, pixels dropped per bounce (0 disables descent)
INVULN_CYCLES, 6250000, invulnerable cycles after a non-fatal hit
DEATH_CYCLES, 12500000, cycles in the dying phase

Ports:
clk25  in  1  25 MHz pixel clock
rst  in  1  synchronous active-high reset
enable  in  1  spawn/keep enemy; low returns to IDLE
bullet_x_flat  in  N_BULLETS*10  bullet i x at [i*10 +: 10]
bullet_y_flat  in  N_BULLETS*10  bullet i y at [i*10 +: 10]
bullet_active_flat  in  N_BULLETS  bullet i valid
enemy_x  out  10  sprite left edge
enemy_y  out  10  sprite top edge
enemy_hp  out  4  current HP
enemy_alive  out  1  high in ALIVE or INVULN
hit_flash  out  1  high in INVULN
enemy_dying  out  1  high in DYING
killed  out  1  one-cycle pulse when HP reaches 0
bullet_hit_flat  out  N_BULLETS  one-cycle pulse per consumed bullet

Behaviour:
- Reset: state IDLE, enemy_x=SPAWN_X, enemy_y=SPAWN_Y, enemy_hp=0, dir=right, all counters 0, every output flag and pulse 0. The clock and reset are one clk25 domain; reset is synchronous, active-high and overrides everything.
- States: IDLE, SPAWN, ALIVE, INVULN, DYING, DEAD.
- enable low in any state: IDLE on the next edge; position, HP and counters reload their reset values.
- IDLE to SPAWN when enable is high. SPAWN lasts one cycle: loads hp=MAX_HP, position SPAWN_X/SPAWN_Y, dir=right, move_cnt=0. It then goes to ALIVE.
- DEAD holds until enable drops. There is no automatic respawn while enable stays high.
- Movement happens in ALIVE and INVULN only; it is frozen in DYING and DEAD.
  - move_cnt counts 0..MOVE_PERIOD-1. At MOVE_PERIOD-1 it wraps to 0 and one step is applied.
  - Compute next x = x ± MOVE_STEP in 11 bits. If next ≥ X_MAX: x=X_MAX and dir=left. If next ≤ X_MIN (or it underflowed): x=X_MIN and dir=right.
  - On either clamp with DESCEND_STEP>0: y = min(y+DESCEND_STEP, Y_MAX).
- Overlap for bullet i: active[i], bx+BULLET_SIZE-1 ≥ ex, bx ≤ ex+SIZE-1, same test on y. All sums use 11-bit arithmetic with no wrap. The test uses the current registered enemy position.
- ALIVE with any overlap at an edge:
  - bullet_hit_flat[i] is registered to 1 for every overlapping i (visible the next cycle, one cycle wide).
  - HP decrements by exactly 1 regardless of how many bullets overlap.
  - If the old hp==1: hp becomes 0, state goes to DYING, and killed pulses one cycle.
  - Otherwise: state goes to INVULN and inv_cnt is cleared.
- INVULN: overlapping bullets are still consumed (bullet_hit pulses), with no HP change. After INVULN_CYCLES cycles the state returns to ALIVE.
- DYING: enemy_dying is high for DEATH_CYCLES cycles, then the state goes to DEAD. No collisions are evaluated in DYING, DEAD, IDLE or SPAWN.
- A move step and a hit in the same cycle both take effect.
- killed and bullet_hit never assert outside the cycle after a qualifying edge. Reset mid-pulse clears them.

Test Plan:
Each scenario uses MOVE_PERIOD=4, INVULN_CYCLES=8, DEATH_CYCLES=5, MAX_HP=3, MOVE_STEP=2, DESCEND_STEP=4.
1. rst, then enable=1 -> SPAWN for 1 cycle, then ALIVE with hp=3, x=320, y=50, enemy_alive=1. x reaches 322 four cycles after entering ALIVE.
2. Force x near X_MAX (run until x=598) -> next step clamps at 598, dir flips, y=54, following step gives x=596. Mirror the check at X_MIN=10.
3. Bullets 0 and 5 both overlapping in one cycle -> bullet_hit_flat=0b100001 for one cycle, hp 3→2, hit_flash high for 8 cycles. A bullet overlapping during INVULN pulses its hit bit but hp stays 2.
4. Three separated hits -> on the third, killed pulses once, hp=0, enemy_alive=0, enemy_dying high for 5 cycles, then DEAD. A further overlapping bullet gives no bullet_hit pulse.
5. In DEAD, toggle enable 0 then 1 -> IDLE, then SPAWN, then ALIVE with hp=3 at (320,50).
6. Assert rst during INVULN and in the killed cycle -> next cycle all outputs are at reset values and the state is IDLE.

Source files
------------

// File: rtl/enemy_controller_param.sv
// Parameterised enemy: spawn, ping-pong movement with optional descent, HP tracking
// against a pool of N_BULLETS bullets, post-hit invulnerability and a timed death phase.

module enemy_hit_lane #(
  parameter int SIZE        = 32,
  parameter int BULLET_SIZE = 8
) (
  input  logic [9:0] i_bx,
  input  logic [9:0] i_by,
  input  logic       i_act,
  input  logic [9:0] i_ex,
  input  logic [9:0] i_ey,
  output logic       o_ovl
);
  localparam logic [10:0] B_EXT = 11'(BULLET_SIZE - 1);
  localparam logic [10:0] E_EXT = 11'(SIZE - 1);

  logic [10:0] w_bx, w_by, w_ex, w_ey;
  logic        w_ovl_x, w_ovl_y;

  // Widen to 11 bits so the far-edge sums never wrap.
  assign w_bx    = {1'b0, i_bx};
  assign w_by    = {1'b0, i_by};
  assign w_ex    = {1'b0, i_ex};
  assign w_ey    = {1'b0, i_ey};
  assign w_ovl_x = (w_bx + B_EXT >= w_ex) && (w_bx <= w_ex + E_EXT);
  assign w_ovl_y = (w_by + B_EXT >= w_ey) && (w_by <= w_ey + E_EXT);
  assign o_ovl   = i_act && w_ovl_x && w_ovl_y;
endmodule

module enemy_controller_param #(
  parameter int N_BULLETS     = 8,
  parameter int SIZE          = 32,
  parameter int BULLET_SIZE   = 8,
  parameter int MAX_HP        = 10,
  parameter int SPAWN_X       = 320,
  parameter int SPAWN_Y       = 50,
  parameter int X_MIN         = 10,
  parameter int X_MAX         = 598,
  parameter int Y_MAX         = 400,
  parameter int MOVE_PERIOD   = 500000,
  parameter int MOVE_STEP     = 2,
  parameter int DESCEND_STEP  = 0,
  parameter int INVULN_CYCLES = 6250000,
  parameter int DEATH_CYCLES  = 12500000
) (
  input  logic                    clk25,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_BULLETS*10-1:0] bullet_x_flat,
  input  logic [N_BULLETS*10-1:0] bullet_y_flat,
  input  logic [N_BULLETS-1:0]    bullet_active_flat,
  output logic [9:0]              enemy_x,
  output logic [9:0]              enemy_y,
  output logic [3:0]              enemy_hp,
  output logic                    enemy_alive,
  output logic                    hit_flash,
  output logic                    enemy_dying,
  output logic                    killed,
  output logic [N_BULLETS-1:0]    bullet_hit_flat
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SPAWN  = 3'd1;
  localparam logic [2:0] ALIVE  = 3'd2;
  localparam logic [2:0] INVULN = 3'd3;
  localparam logic [2:0] DYING  = 3'd4;
  localparam logic [2:0] DEAD   = 3'd5;

  localparam int MW = $clog2(MOVE_PERIOD + 1);
  localparam int IW = $clog2(INVULN_CYCLES + 1);
  localparam int DW = $clog2(DEATH_CYCLES + 1);

  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_PERIOD - 1);
  localparam logic [IW-1:0] INV_LAST   = IW'(INVULN_CYCLES - 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_CYCLES - 1);

  localparam logic [9:0]  SPX    = 10'(SPAWN_X);
  localparam logic [9:0]  SPY    = 10'(SPAWN_Y);
  localparam logic [3:0]  HP0    = 4'(MAX_HP);
  localparam logic [10:0] STEP11 = 11'(MOVE_STEP);
  localparam logic [10:0] DESC11 = 11'(DESCEND_STEP);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);

  logic [2:0]           r_state;
  logic [9:0]           r_x, r_y;
  logic [3:0]           r_hp;
  logic                 r_dir;      // 0 = right, 1 = left
  logic [MW-1:0]        r_move_cnt;
  logic [IW-1:0]        r_inv_cnt;
  logic [DW-1:0]        r_death_cnt;
  logic                 r_killed;
  logic [N_BULLETS-1:0] r_hit;

  logic [N_BULLETS-1:0] w_ovl;
  logic                 w_any;
  logic                 w_step;
  logic [10:0]          w_nx, w_ny_sum, w_ny;
  logic                 w_under, w_at_max, w_at_min;

  genvar gi;
  generate
    for (gi = 0; gi < N_BULLETS; gi++) begin : g_lane
      enemy_hit_lane #(.SIZE(SIZE), .BULLET_SIZE(BULLET_SIZE)) u_lane (
        .i_bx  (bullet_x_flat[gi*10 +: 10]),
        .i_by  (bullet_y_flat[gi*10 +: 10]),
        .i_act (bullet_active_flat[gi]),
        .i_ex  (r_x),
        .i_ey  (r_y),
        .o_ovl (w_ovl[gi])
      );
    end
  endgenerate

  assign w_any  = |w_ovl;
  assign w_step = (r_move_cnt == MOVE_LAST);

  // Left moves can wrap in 11 bits; treat that as hitting the left bound.
  always_comb begin
    w_nx     = r_dir ? ({1'b0, r_x} - STEP11) : ({1'b0, r_x} + STEP11);
    w_under  = r_dir && ({1'b0, r_x} < STEP11);
    w_at_max = !w_under && (w_nx >= XMAX11);
    w_at_min = !w_at_max && (w_under || (w_nx <= XMIN11));
    w_ny_sum = {1'b0, r_y} + DESC11;
    w_ny     = (w_ny_sum > YMAX11) ? YMAX11 : w_ny_sum;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= SPX;
      r_y         <= SPY;
      r_hp        <= '0;
      r_dir       <= 1'b0;
      r_move_cnt  <= '0;
      r_inv_cnt   <= '0;
      r_death_cnt <= '0;
      r_killed    <= 1'b0;
      r_hit       <= '0;
    end else begin
      r_killed <= 1'b0;
      r_hit    <= '0;
      if (!enable) begin
        r_state     <= IDLE;
        r_x         <= SPX;
        r_y         <= SPY;
        r_hp        <= '0;
        r_dir       <= 1'b0;
        r_move_cnt  <= '0;
        r_inv_cnt   <= '0;
        r_death_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= SPAWN;
          SPAWN: begin
            r_hp       <= HP0;
            r_x        <= SPX;
            r_y        <= SPY;
            r_dir      <= 1'b0;
            r_move_cnt <= '0;
            r_state    <= ALIVE;
          end
          ALIVE, INVULN: begin
            if (w_step) begin
              r_move_cnt <= '0;
              if (w_at_max) begin
                r_x   <= XMAX11[9:0];
                r_dir <= 1'b1;
              end else if (w_at_min) begin
                r_x   <= XMIN11[9:0];
                r_dir <= 1'b0;
              end else begin
                r_x <= w_nx[9:0];
              end
              if ((DESCEND_STEP > 0) && (w_at_max || w_at_min))
                r_y <= w_ny[9:0];
            end else begin
              r_move_cnt <= r_move_cnt + 1'b1;
            end
            r_hit <= w_ovl;
            if (r_state == ALIVE) begin
              // One HP per hit cycle, however many bullets landed.
              if (w_any) begin
                r_hp <= r_hp - 1'b1;
                if (r_hp == 4'd1) begin
                  r_state     <= DYING;
                  r_killed    <= 1'b1;
                  r_death_cnt <= '0;
                end else begin
                  r_state   <= INVULN;
                  r_inv_cnt <= '0;
                end
              end
            end else if (r_inv_cnt == INV_LAST) begin
              r_state <= ALIVE;
            end else begin
              r_inv_cnt <= r_inv_cnt + 1'b1;
            end
          end
          DYING: begin
            if (r_death_cnt == DEATH_LAST) r_state <= DEAD;
            else r_death_cnt <= r_death_cnt + 1'b1;
          end
          DEAD: r_state <= DEAD;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign enemy_x         = r_x;
  assign enemy_y         = r_y;
  assign enemy_hp        = r_hp;
  assign enemy_alive     = (r_state == ALIVE) || (r_state == INVULN);
  assign hit_flash       = (r_state == INVULN);
  assign enemy_dying     = (r_state == DYING);
  assign killed          = r_killed;
  assign bullet_hit_flat = r_hit;
endmodule

// File: tb/tb_enemy_controller_param.sv
// Directed bench for enemy_controller_param: spawn, bounce/descent, hits, invuln, death, reset.

module tb_enemy_controller_param;
  localparam int NB = 8;

  logic           clk25 = 1'b0;
  logic           rst;
  logic           enable;
  logic [NB*10-1:0] bx_flat, by_flat;
  logic [NB-1:0]  bact;
  logic [9:0]     ex, ey;
  logic [3:0]     hp;
  logic           alive, flash, dying, killed;
  logic [NB-1:0]  bhit;

  int n_chk = 0;
  int n_err = 0;

  enemy_controller_param #(
    .N_BULLETS(NB), .MAX_HP(3), .MOVE_PERIOD(4), .MOVE_STEP(2),
    .DESCEND_STEP(4), .INVULN_CYCLES(8), .DEATH_CYCLES(5)
  ) dut (
    .clk25(clk25), .rst(rst), .enable(enable),
    .bullet_x_flat(bx_flat), .bullet_y_flat(by_flat), .bullet_active_flat(bact),
    .enemy_x(ex), .enemy_y(ey), .enemy_hp(hp), .enemy_alive(alive),
    .hit_flash(flash), .enemy_dying(dying), .killed(killed), .bullet_hit_flat(bhit)
  );

  always #20 clk25 = ~clk25;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic set_bul(input int i, input int x, input int y, input bit a);
    bx_flat[i*10 +: 10] = 10'(x);
    by_flat[i*10 +: 10] = 10'(y);
    bact[i] = a;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; bx_flat = '0; by_flat = '0; bact = '0;
    tick(); tick();
    chk("rst_x", 32'(ex), 320);
    chk("rst_y", 32'(ey), 50);
    chk("rst_hp", 32'(hp), 0);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_flash", 32'(flash), 0);
    chk("rst_dying", 32'(dying), 0);
    chk("rst_killed", 32'(killed), 0);
    chk("rst_hit", 32'(bhit), 0);
    rst = 1'b0;

    // spawn
    enable = 1'b1;
    tick();
    chk("spawn_alive", 32'(alive), 0);
    chk("spawn_hp", 32'(hp), 0);
    tick();
    chk("alive_hp", 32'(hp), 3);
    chk("alive_x", 32'(ex), 320);
    chk("alive_y", 32'(ey), 50);
    chk("alive_flag", 32'(alive), 1);
    repeat (3) tick();
    chk("x_before_step", 32'(ex), 320);
    tick();
    chk("x_first_step", 32'(ex), 322);

    // right bound: 137 steps to 596, then clamp at 598
    repeat (548) tick();
    chk("x_596", 32'(ex), 596);
    chk("y_pre_bounce", 32'(ey), 50);
    repeat (4) tick();
    chk("x_clamp_max", 32'(ex), 598);
    chk("y_desc_1", 32'(ey), 54);
    repeat (3) tick();
    chk("x_hold_598", 32'(ex), 598);
    tick();
    chk("x_left_596", 32'(ex), 596);
    // left bound: 292 steps to 12, then clamp at 10
    repeat (1168) tick();
    chk("x_12", 32'(ex), 12);
    repeat (4) tick();
    chk("x_clamp_min", 32'(ex), 10);
    chk("y_desc_2", 32'(ey), 58);
    repeat (4) tick();
    chk("x_right_12", 32'(ex), 12);

    // double hit with a non-overlapping active decoy
    set_bul(0, 40, 60, 1); set_bul(5, 40, 60, 1); set_bul(2, 200, 200, 1);
    tick();
    chk("dbl_hit", 32'(bhit), 32'h21);
    chk("dbl_hp", 32'(hp), 2);
    chk("dbl_flash", 32'(flash), 1);
    chk("dbl_alive", 32'(alive), 1);
    set_bul(0, 40, 60, 0); set_bul(5, 40, 60, 0);
    tick();
    chk("hit_pulse_end", 32'(bhit), 0);
    chk("inv_flash_2", 32'(flash), 1);
    set_bul(1, 40, 60, 1);
    tick();
    chk("inv_hit", 32'(bhit), 32'h02);
    chk("inv_hp", 32'(hp), 2);
    set_bul(1, 40, 60, 0);
    repeat (5) tick();
    chk("inv_flash_8", 32'(flash), 1);
    tick();
    chk("inv_over", 32'(flash), 0);
    chk("inv_over_alive", 32'(alive), 1);

    // second and third hits
    set_bul(3, 40, 60, 1);
    tick();
    chk("hit2_bits", 32'(bhit), 32'h08);
    chk("hit2_hp", 32'(hp), 1);
    set_bul(3, 40, 60, 0);
    repeat (8) tick();
    chk("hit2_flash_end", 32'(flash), 0);
    set_bul(7, 40, 60, 1);
    tick();
    chk("kill_pulse", 32'(killed), 1);
    chk("kill_hp", 32'(hp), 0);
    chk("kill_alive", 32'(alive), 0);
    chk("kill_dying", 32'(dying), 1);
    chk("kill_hit", 32'(bhit), 32'h80);
    tick();
    chk("kill_pulse_end", 32'(killed), 0);
    chk("dying_no_hit", 32'(bhit), 0);
    repeat (3) tick();
    chk("dying_5th", 32'(dying), 1);
    tick();
    chk("dead_dying", 32'(dying), 0);
    chk("dead_alive", 32'(alive), 0);
    tick();
    chk("dead_no_hit", 32'(bhit), 0);
    chk("dead_no_kill", 32'(killed), 0);
    set_bul(7, 40, 60, 0); set_bul(2, 200, 200, 0);

    // re-enable from DEAD
    enable = 1'b0;
    tick();
    chk("idle_hp", 32'(hp), 0);
    chk("idle_x", 32'(ex), 320);
    chk("idle_y", 32'(ey), 50);
    enable = 1'b1;
    tick();
    chk("respawn_spawn", 32'(alive), 0);
    tick();
    chk("respawn_alive", 32'(alive), 1);
    chk("respawn_hp", 32'(hp), 3);
    chk("respawn_x", 32'(ex), 320);

    // reset during INVULN
    set_bul(4, 340, 60, 1);
    tick();
    chk("r6_hit", 32'(bhit), 32'h10);
    set_bul(4, 340, 60, 0);
    tick();
    chk("r6_inv", 32'(flash), 1);
    rst = 1'b1;
    tick();
    chk("r6_flash", 32'(flash), 0);
    chk("r6_hp", 32'(hp), 0);
    chk("r6_alive", 32'(alive), 0);
    rst = 1'b0;
    tick();
    chk("r6_idle_spawn", 32'(alive), 0);
    tick();
    chk("r6_realive_hp", 32'(hp), 3);

    // reset in the killed cycle
    set_bul(4, 340, 60, 1); tick(); set_bul(4, 340, 60, 0);
    repeat (8) tick();
    set_bul(4, 340, 60, 1); tick(); set_bul(4, 340, 60, 0);
    chk("r6b_hp1", 32'(hp), 1);
    repeat (8) tick();
    set_bul(4, 340, 60, 1);
    tick();
    chk("r6b_killed", 32'(killed), 1);
    set_bul(4, 340, 60, 0);
    rst = 1'b1;
    tick();
    chk("r6b_killed_clr", 32'(killed), 0);
    chk("r6b_dying_clr", 32'(dying), 0);
    chk("r6b_hit_clr", 32'(bhit), 0);
    chk("r6b_x", 32'(ex), 320);
    chk("r6b_y", 32'(ey), 50);
    rst = 1'b0;
    tick();
    chk("r6b_spawn", 32'(alive), 0);
    tick();
    chk("r6b_alive", 32'(alive), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
